// File: rtl/mux_pkg.sv
// Shared constants and types for the registered N:1 selector.
package mux_pkg;

   localparam logic MODE_DIRECT = 1'b0;
   localparam logic MODE_RR     = 1'b1;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } out_state_e;

endpackage

// File: rtl/mux_sel_rr_rr_pick.sv
// Round-robin search: first requester at or after ptr_i, wrapping modulo N.
module rr_pick #(
   parameter  int N  = 4,
   localparam int SW = $clog2(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [SW-1:0] ptr_i,
   output logic          found_o,
   output logic [SW-1:0] idx_o
);

   logic [2*N-1:0] dbl;
   logic [N-1:0]   rot;
   logic [SW:0]    pos;
   logic [SW:0]    sum;

   always_comb begin
      // Doubling the vector makes the rotate correct for any N, not just powers of two.
      dbl     = {req_i, req_i} >> ptr_i;
      rot     = dbl[N-1:0];
      found_o = 1'b0;
      pos     = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (rot[i]) begin
            found_o = 1'b1;
            pos     = (SW+1)'(i);
         end
      end
      sum = pos + {1'b0, ptr_i};
      if (sum >= (SW+1)'(N)) begin
         sum = sum - (SW+1)'(N);
      end
      idx_o = sum[SW-1:0];
   end

endmodule

// File: rtl/mux_sel_rr.sv
// N-channel selector with direct or round-robin choice and a one-entry output register.
//    state    | meaning
//    ST_EMPTY | output register holds no word (out_valid_o = 0)
//    ST_FULL  | output register holds a word awaiting out_ready_i
module mux_sel_rr
   import mux_pkg::*;
#(
   parameter  int N  = 4,
   parameter  int W  = 8,
   localparam int SW = $clog2(N)
) (
   input  logic           clk_i,
   input  logic           rst_n_i,
   input  logic           mode_i,
   input  logic [SW-1:0]  sel_i,
   input  logic [N*W-1:0] in_data_i,
   input  logic [N-1:0]   in_valid_i,
   output logic [N-1:0]   in_ready_o,
   output logic [W-1:0]   out_data_o,
   output logic [SW-1:0]  out_ch_o,
   output logic           out_valid_o,
   input  logic           out_ready_i
);

   out_state_e    state_q, state_d;
   logic [W-1:0]  data_q, data_d;
   logic [SW-1:0] ch_q, ch_d;
   logic [SW-1:0] ptr_q, ptr_d;
   logic          rr_found;
   logic [SW-1:0] rr_idx;
   logic [SW-1:0] cand;
   logic          cand_ok;
   logic          load_en;
   logic          xfer;

   rr_pick #(.N(N)) u_pick (
      .req_i   (in_valid_i),
      .ptr_i   (ptr_q),
      .found_o (rr_found),
      .idx_o   (rr_idx)
   );

   assign load_en = (state_q == ST_EMPTY) || out_ready_i;

   always_comb begin
      cand    = sel_i;
      cand_ok = ({1'b0, sel_i} < (SW+1)'(N));
      if (mode_i == MODE_RR) begin
         cand    = rr_idx;
         cand_ok = rr_found;
      end
   end

   always_comb begin
      in_ready_o = '0;
      if (cand_ok) begin
         in_ready_o[cand] = load_en;
      end
   end

   assign xfer = cand_ok && load_en && in_valid_i[cand];

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      ch_d    = ch_q;
      ptr_d   = ptr_q;
      if (xfer) begin
         state_d = ST_FULL;
         data_d  = in_data_i[int'(cand)*W +: W];
         ch_d    = cand;
         if (mode_i == MODE_RR) begin
            ptr_d = (int'(cand) == N - 1) ? '0 : cand + SW'(1);
         end
      end else if (out_ready_i) begin
         state_d = ST_EMPTY;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= ST_EMPTY;
         data_q  <= '0;
         ch_q    <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         ch_q    <= ch_d;
         ptr_q   <= ptr_d;
      end
   end

   assign out_valid_o = (state_q == ST_FULL);
   assign out_data_o  = data_q;
   assign out_ch_o    = ch_q;

endmodule

// File: doc/mux_sel_rr.md
# mux_sel_rr

Parametrised N-channel, W-bit registered selector, the successor to the combinational 4:1 data-path mux. It picks one of N valid/ready input channels, either by an explicit select code (direct mode) or by round-robin arbitration among requesting channels, and holds the chosen word in a one-entry output register with a valid/ready handshake. It sits between the register-file and ALU operand paths in the course datapath, wherever multiple sources share one consumer.

## Interface
- N, default 4: number of input channels, 2..16.
- W, default 8: data width per channel, 1..32.
- SW, default $clog2(N): select and channel-ID width; derived, never overridden.

- CLK  input  1  sole clock; all state updates on the rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- MODE  input  1  0 = direct select, 1 = round-robin.
- SEL  input  SW  channel code in direct mode; ignored in round-robin mode.
- IN_DATA  input  N*W  channel i occupies bits [i*W +: W].
- IN_VALID  input  N  per-channel request.
- IN_READY  output  N  per-channel accept; combinational, at most one bit high.
- OUT_DATA  output  W  registered selected word.
- OUT_CH  output  SW  index of the channel that supplied OUT_DATA.
- OUT_VALID  output  1  output register holds a word.
- OUT_READY  input  1  consumer accepts the word.

## Operation
- Output register: two states, EMPTY (OUT_VALID=0) and FULL (OUT_VALID=1).
- load_en = !OUT_VALID || OUT_READY.
- Candidate channel c:
  - Direct mode: c = SEL.
  - Round-robin mode: c = first i with IN_VALID[i]=1, searching PTR, PTR+1, …, N-1, 0, …, PTR-1.
- IN_READY[c] = load_en when c is defined; all other IN_READY bits are 0.
- Transfer on channel c when IN_VALID[c] && IN_READY[c]. At the next edge OUT_DATA ← IN_DATA[c], OUT_CH ← c, OUT_VALID ← 1.
- If there is no transfer and OUT_READY=1, OUT_VALID ← 0. OUT_DATA and OUT_CH keep their last values.
- Simultaneous pop and push in the same cycle: the register reloads and OUT_VALID stays 1.
- PTR (SW bits) updates only on a transfer in round-robin mode: PTR ← c+1, wrapping from N-1 to 0. The wrap is explicit, so it is also correct when N is not a power of two.
- Direct mode leaves PTR unchanged.
- Direct mode with SEL ≥ N (only possible when N is not a power of two): no candidate, all IN_READY = 0, no transfer.
- Round-robin mode with no IN_VALID bit set: no candidate, all IN_READY = 0.
- MODE and SEL changes take effect in the same cycle; no drain is needed.
- Input-side rule: a channel whose IN_VALID is high must keep IN_DATA stable until it sees IN_READY high.

## Timing
- Reset values: OUT_VALID=0, OUT_DATA=0, OUT_CH=0, PTR=0. IN_READY is therefore all zero except the candidate bit, which is 1 (the register is EMPTY).
- Reset asserted mid-transfer: the word in flight is discarded; no partial state survives.
- Latency: 1 cycle from an input transfer to OUT_VALID.
- Throughput: 1 word per cycle while OUT_READY is held high.
- Back-pressure: while OUT_VALID && !OUT_READY, OUT_DATA and OUT_CH are held stable and all IN_READY bits are 0.
- Combinational paths: IN_VALID, MODE, SEL and OUT_READY → IN_READY. There is no combinational path from inputs to OUT_*.
- Fairness: in round-robin mode with all channels continuously valid and OUT_READY=1, grants cycle 0,1,…,N-1,0,… with no channel starved.

## Structure
- Shared package mux_pkg holds the mode constants MODE_DIRECT=1'b0 and MODE_RR=1'b1.
- Sub-module rr_pick, parameter N: inputs are the request vector and PTR; outputs are found (1 bit) and idx (SW bits).
- rr_pick is purely combinational and implements the rotate, priority-encode and un-rotate search.
- The top level holds the output register, PTR, the load_en logic and the IN_READY decode.

## Test plan
- Reset with N=4, W=8: hold RST_N=0 → OUT_VALID=0, OUT_DATA=0, OUT_CH=0. Release RST_N, MODE=0, SEL=2, IN_VALID=0100, IN_DATA ch2=8'hC3 → IN_READY=0100; the next cycle OUT_DATA=C3, OUT_CH=2, OUT_VALID=1.
- Direct-mode back-pressure: OUT_READY=0 for 3 cycles while SEL switches 2→1 → OUT_DATA stays C3 and IN_READY=0000. Raise OUT_READY with ch1=8'h5A valid → the next cycle OUT_DATA=5A, OUT_CH=1.
- Round-robin fairness: MODE=1, IN_VALID=1111, OUT_READY=1 for 8 cycles → OUT_CH sequence is 0,1,2,3,0,1,2,3.
- Round-robin skip and wrap: PTR=3, IN_VALID=0010 → grant to ch1, then PTR=2. Next IN_VALID=1001 → grant to ch3, then PTR=0 (wrap).
- Non-power-of-two: N=3, MODE=0, SEL=3, IN_VALID=111 → IN_READY=000 and OUT_VALID does not rise. Then MODE=1 → grants cycle 0,1,2,0.
- Reset mid-operation: OUT_VALID=1, OUT_READY=0, PTR=2, then pulse RST_N low for half a cycle → OUT_VALID=0 immediately, and the first round-robin grant after reset goes to ch0.
